// File: rtl/branch_predictor.sv
// ============================================================================
// branch_predictor
// Direct-mapped 2-bit BHT/BTB predictor with mispredict detection and counters.
// Revision: 1.0
// ============================================================================
`default_nettype none

module branch_predictor #(
   parameter int DATA_WIDTH  = 32,
   parameter int BHT_ENTRIES = 64,
   parameter int CNT_W       = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DATA_WIDTH-1:0] fetch_pc_i,
   output logic                  pred_taken_o,
   output logic [DATA_WIDTH-1:0] pred_target_o,
   input  logic                  upd_valid_i,
   input  logic [DATA_WIDTH-1:0] upd_pc_i,
   input  logic                  upd_taken_i,
   input  logic [DATA_WIDTH-1:0] upd_target_i,
   input  logic                  upd_pred_taken_i,
   input  logic [DATA_WIDTH-1:0] upd_pred_target_i,
   output logic                  mispredict_o,
   output logic [DATA_WIDTH-1:0] redirect_pc_o,
   output logic [CNT_W-1:0]      branch_cnt_o,
   output logic [CNT_W-1:0]      mispredict_cnt_o
);

   localparam int c_idx_w = $clog2(BHT_ENTRIES);
   localparam int c_tag_w = DATA_WIDTH - c_idx_w - 2;
   localparam logic [DATA_WIDTH-1:0] c_pc_step = DATA_WIDTH'(4);
   localparam logic [1:0] c_cnt_weak_nt = 2'b01;
   localparam logic [1:0] c_cnt_weak_t  = 2'b10;

   logic [BHT_ENTRIES-1:0] valid_q, valid_d;
   logic [1:0]             cnt_q [BHT_ENTRIES];
   logic [1:0]             cnt_d [BHT_ENTRIES];
   logic [c_tag_w-1:0]     tag_q [BHT_ENTRIES];
   logic [c_tag_w-1:0]     tag_d [BHT_ENTRIES];
   logic [DATA_WIDTH-1:0]  tgt_q [BHT_ENTRIES];
   logic [DATA_WIDTH-1:0]  tgt_d [BHT_ENTRIES];
   logic [CNT_W-1:0]       branch_cnt_q, branch_cnt_d;
   logic [CNT_W-1:0]       mispredict_cnt_q, mispredict_cnt_d;

   logic [c_idx_w-1:0] w_f_idx, w_u_idx;
   logic [c_tag_w-1:0] w_f_tag, w_u_tag;
   logic               w_f_hit, w_u_hit;

   assign w_f_idx = fetch_pc_i[c_idx_w+1:2];
   assign w_f_tag = fetch_pc_i[DATA_WIDTH-1:c_idx_w+2];
   assign w_u_idx = upd_pc_i[c_idx_w+1:2];
   assign w_u_tag = upd_pc_i[DATA_WIDTH-1:c_idx_w+2];

   assign w_f_hit = valid_q[w_f_idx] && (tag_q[w_f_idx] == w_f_tag);
   assign w_u_hit = valid_q[w_u_idx] && (tag_q[w_u_idx] == w_u_tag);

   // Prediction reads registered state only, so a same-cycle update is not bypassed.
   assign pred_taken_o  = w_f_hit && cnt_q[w_f_idx][1];
   assign pred_target_o = pred_taken_o ? tgt_q[w_f_idx] : fetch_pc_i + c_pc_step;

   assign mispredict_o  = rst_n && upd_valid_i &&
                          ((upd_taken_i != upd_pred_taken_i) ||
                           (upd_taken_i && (upd_target_i != upd_pred_target_i)));
   assign redirect_pc_o = upd_taken_i ? upd_target_i : upd_pc_i + c_pc_step;

   assign branch_cnt_o     = branch_cnt_q;
   assign mispredict_cnt_o = mispredict_cnt_q;

   always_comb begin
      valid_d          = valid_q;
      cnt_d            = cnt_q;
      tag_d            = tag_q;
      tgt_d            = tgt_q;
      branch_cnt_d     = branch_cnt_q;
      mispredict_cnt_d = mispredict_cnt_q;
      if (upd_valid_i) begin
         branch_cnt_d = branch_cnt_q + CNT_W'(1);
         if (mispredict_o) begin
            mispredict_cnt_d = mispredict_cnt_q + CNT_W'(1);
         end
         if (w_u_hit) begin
            if (upd_taken_i) begin
               if (cnt_q[w_u_idx] != 2'b11) begin
                  cnt_d[w_u_idx] = cnt_q[w_u_idx] + 2'b01;
               end
               tgt_d[w_u_idx] = upd_target_i;
            end else if (cnt_q[w_u_idx] != 2'b00) begin
               cnt_d[w_u_idx] = cnt_q[w_u_idx] - 2'b01;
            end
         end else if (upd_taken_i) begin
            // Only taken branches earn an entry; not-taken misses predict fall-through anyway.
            valid_d[w_u_idx] = 1'b1;
            tag_d[w_u_idx]   = w_u_tag;
            tgt_d[w_u_idx]   = upd_target_i;
            cnt_d[w_u_idx]   = c_cnt_weak_t;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q          <= '0;
         branch_cnt_q     <= '0;
         mispredict_cnt_q <= '0;
         for (int i = 0; i < BHT_ENTRIES; i++) begin
            cnt_q[i] <= c_cnt_weak_nt;
            tag_q[i] <= '0;
            tgt_q[i] <= '0;
         end
      end else begin
         valid_q          <= valid_d;
         cnt_q            <= cnt_d;
         tag_q            <= tag_d;
         tgt_q            <= tgt_d;
         branch_cnt_q     <= branch_cnt_d;
         mispredict_cnt_q <= mispredict_cnt_d;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_branch_predictor.sv
// ============================================================================
// tb_branch_predictor
// Directed table, reset-during-update sequence and randomized model comparison.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_branch_predictor;

   localparam int N_ENT = 64;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] fetch_pc_i;
   logic        pred_taken_o;
   logic [31:0] pred_target_o;
   logic        upd_valid_i;
   logic [31:0] upd_pc_i;
   logic        upd_taken_i;
   logic [31:0] upd_target_i;
   logic        upd_pred_taken_i;
   logic [31:0] upd_pred_target_i;
   logic        mispredict_o;
   logic [31:0] redirect_pc_o;
   logic [31:0] branch_cnt_o;
   logic [31:0] mispredict_cnt_o;

   branch_predictor #(.DATA_WIDTH(32), .BHT_ENTRIES(N_ENT), .CNT_W(32)) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .fetch_pc_i        (fetch_pc_i),
      .pred_taken_o      (pred_taken_o),
      .pred_target_o     (pred_target_o),
      .upd_valid_i       (upd_valid_i),
      .upd_pc_i          (upd_pc_i),
      .upd_taken_i       (upd_taken_i),
      .upd_target_i      (upd_target_i),
      .upd_pred_taken_i  (upd_pred_taken_i),
      .upd_pred_target_i (upd_pred_target_i),
      .mispredict_o      (mispredict_o),
      .redirect_pc_o     (redirect_pc_o),
      .branch_cnt_o      (branch_cnt_o),
      .mispredict_cnt_o  (mispredict_cnt_o)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // Reference model: plain arrays of entry fields plus event tallies.
   bit          m_valid [N_ENT];
   int          m_cnt   [N_ENT];
   int unsigned m_tag   [N_ENT];
   logic [31:0] m_tgt   [N_ENT];
   int unsigned m_bcnt, m_mcnt;

   typedef struct {
      logic [31:0] f;
      logic        uv;
      logic [31:0] upc;
      logic        ut;
      logic [31:0] utgt;
      logic        uptk;
      logic [31:0] uptgt;
      logic        eptk;
      logic [31:0] eptgt;
      logic        emp;
      logic [31:0] eredir;
      int          ebc;
      int          emc;
   } vec_t;

   vec_t vt[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic int midx(input logic [31:0] pc);
      return int'((pc >> 2) % N_ENT);
   endfunction

   function automatic bit mhit(input logic [31:0] pc);
      return m_valid[midx(pc)] && (m_tag[midx(pc)] == (pc >> 8));
   endfunction

   task automatic model_reset();
      for (int i = 0; i < N_ENT; i++) begin
         m_valid[i] = 0; m_cnt[i] = 1; m_tag[i] = 0; m_tgt[i] = '0;
      end
      m_bcnt = 0; m_mcnt = 0;
   endtask

   task automatic model_predict(input logic [31:0] pc, output logic tk, output logic [31:0] tg);
      tk = mhit(pc) && (m_cnt[midx(pc)] >= 2);
      tg = tk ? m_tgt[midx(pc)] : pc + 32'd4;
   endtask

   function automatic logic model_mp();
      if (!upd_valid_i) return 1'b0;
      if (upd_taken_i != upd_pred_taken_i) return 1'b1;
      return upd_taken_i && (upd_target_i != upd_pred_target_i);
   endfunction

   task automatic model_train();
      int i;
      if (!upd_valid_i) return;
      i = midx(upd_pc_i);
      m_bcnt++;
      if (model_mp()) m_mcnt++;
      if (mhit(upd_pc_i)) begin
         if (upd_taken_i) begin
            m_cnt[i] = (m_cnt[i] == 3) ? 3 : m_cnt[i] + 1;
            m_tgt[i] = upd_target_i;
         end else begin
            m_cnt[i] = (m_cnt[i] == 0) ? 0 : m_cnt[i] - 1;
         end
      end else if (upd_taken_i) begin
         m_valid[i] = 1; m_tag[i] = upd_pc_i >> 8; m_tgt[i] = upd_target_i; m_cnt[i] = 2;
      end
   endtask

   task automatic drive(input logic [31:0] f, input logic uv, input logic [31:0] upc,
                        input logic ut, input logic [31:0] utgt,
                        input logic uptk, input logic [31:0] uptgt);
      fetch_pc_i = f; upd_valid_i = uv; upd_pc_i = upc; upd_taken_i = ut;
      upd_target_i = utgt; upd_pred_taken_i = uptk; upd_pred_target_i = uptgt;
      #3;
   endtask

   task automatic tick();
      @(posedge clk);
      model_train();
      #1;
   endtask

   task automatic add(input logic [31:0] f, input logic uv, input logic [31:0] upc,
                      input logic ut, input logic [31:0] utgt, input logic uptk,
                      input logic [31:0] uptgt, input logic eptk, input logic [31:0] eptgt,
                      input logic emp, input logic [31:0] eredir, input int ebc, input int emc);
      vec_t r;
      r.f = f; r.uv = uv; r.upc = upc; r.ut = ut; r.utgt = utgt; r.uptk = uptk;
      r.uptgt = uptgt; r.eptk = eptk; r.eptgt = eptgt; r.emp = emp; r.eredir = eredir;
      r.ebc = ebc; r.emc = emc;
      vt.push_back(r);
   endtask

   initial begin
      logic        etk;
      logic [31:0] etg;
      logic [31:0] f, upc;

      // fetch  uv upc   ut utgt  uptk uptgt | ptk ptgt  mp redir bc mc
      add(32'h100, 0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 32'h104, 0, 32'h4,   0, 0);
      add(32'h100, 1, 32'h100, 1, 32'h80,  0, 32'h104, 0, 32'h104, 1, 32'h80,  0, 0);
      add(32'h100, 1, 32'h100, 1, 32'h80,  0, 32'h104, 1, 32'h80,  1, 32'h80,  1, 1);
      add(32'h100, 0, 32'h0,   0, 32'h0,   0, 32'h0,   1, 32'h80,  0, 32'h4,   2, 2);
      add(32'h100, 1, 32'h100, 1, 32'h80,  1, 32'h80,  1, 32'h80,  0, 32'h80,  2, 2);
      add(32'h100, 1, 32'h100, 1, 32'h80,  1, 32'h80,  1, 32'h80,  0, 32'h80,  3, 2);
      add(32'h100, 1, 32'h100, 1, 32'h80,  1, 32'h80,  1, 32'h80,  0, 32'h80,  4, 2);
      add(32'h100, 1, 32'h100, 1, 32'h80,  1, 32'h80,  1, 32'h80,  0, 32'h80,  5, 2);
      add(32'h100, 1, 32'h100, 0, 32'h80,  1, 32'h80,  1, 32'h80,  1, 32'h104, 6, 2);
      add(32'h100, 0, 32'h0,   0, 32'h0,   0, 32'h0,   1, 32'h80,  0, 32'h4,   7, 3);
      add(32'h100, 1, 32'h100, 0, 32'h80,  1, 32'h80,  1, 32'h80,  1, 32'h104, 7, 3);
      add(32'h100, 0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 32'h104, 0, 32'h4,   8, 4);
      add(32'h200, 1, 32'h200, 1, 32'h300, 0, 32'h204, 0, 32'h204, 1, 32'h300, 8, 4);
      add(32'h100, 0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 32'h104, 0, 32'h4,   9, 5);
      add(32'h200, 0, 32'h0,   0, 32'h0,   0, 32'h0,   1, 32'h300, 0, 32'h4,   9, 5);
      add(32'hFFFFFFFC, 0, 32'h0, 0, 32'h0, 0, 32'h0,  0, 32'h0,   0, 32'h4,   9, 5);
      add(32'h200, 1, 32'h200, 0, 32'h300, 1, 32'h300, 1, 32'h300, 1, 32'h204, 9, 5);
      add(32'h200, 0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 32'h204, 0, 32'h4,  10, 6);
      add(32'h100, 0, 32'h100, 1, 32'h500, 0, 32'h104, 0, 32'h104, 0, 32'h500,10, 6);
      add(32'h100, 0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 32'h104, 0, 32'h4,  10, 6);
      add(32'h400, 1, 32'h400, 0, 32'h0,   0, 32'h404, 0, 32'h404, 0, 32'h404,10, 6);
      add(32'h200, 0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 32'h204, 0, 32'h4,  11, 6);
      add(32'h200, 1, 32'h200, 1, 32'h340, 1, 32'h300, 0, 32'h204, 1, 32'h340,11, 6);
      add(32'h200, 0, 32'h0,   0, 32'h0,   0, 32'h0,   1, 32'h340, 0, 32'h4,  12, 7);

      rst_n = 1'b0;
      drive(32'h100, 1, 32'h100, 1, 32'h80, 0, 32'h104);
      chk("mp_in_reset", {31'b0, mispredict_o}, 32'h0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();

      foreach (vt[k]) begin
         drive(vt[k].f, vt[k].uv, vt[k].upc, vt[k].ut, vt[k].utgt, vt[k].uptk, vt[k].uptgt);
         chk($sformatf("v%0d_ptk", k),   {31'b0, pred_taken_o}, {31'b0, vt[k].eptk});
         chk($sformatf("v%0d_ptgt", k),  pred_target_o,         vt[k].eptgt);
         chk($sformatf("v%0d_mp", k),    {31'b0, mispredict_o}, {31'b0, vt[k].emp});
         chk($sformatf("v%0d_redir", k), redirect_pc_o,         vt[k].eredir);
         chk($sformatf("v%0d_bcnt", k),  branch_cnt_o,          32'(vt[k].ebc));
         chk($sformatf("v%0d_mcnt", k),  mispredict_cnt_o,      32'(vt[k].emc));
         tick();
      end

      // Reset lands between an update's setup and its clock edge.
      drive(32'h200, 1, 32'h100, 1, 32'h80, 0, 32'h104);
      chk("pre_rst_mp", {31'b0, mispredict_o}, 32'h1);
      rst_n = 1'b0;
      #1;
      chk("rst_mp",   {31'b0, mispredict_o}, 32'h0);
      chk("rst_ptk",  {31'b0, pred_taken_o}, 32'h0);
      chk("rst_ptgt", pred_target_o, 32'h204);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
      drive(32'h100, 0, 32'h0, 0, 32'h0, 0, 32'h0);
      chk("rst_bcnt", branch_cnt_o, 32'h0);
      chk("rst_mcnt", mispredict_cnt_o, 32'h0);
      chk("rst_lost_ptk", {31'b0, pred_taken_o}, 32'h0);
      chk("rst_lost_ptgt", pred_target_o, 32'h104);
      tick();

      for (int n = 0; n < 600; n++) begin
         f   = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
         upc = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
         if ($urandom_range(0, 7) == 0) upc = $urandom;
         fetch_pc_i = f; upd_pc_i = upc;
         upd_valid_i = ($urandom_range(0, 9) < 7);
         upd_taken_i = $urandom_range(0, 1);
         upd_target_i = ($urandom_range(0, 1) == 0) ? (32'h1000 | ($urandom_range(0, 3) << 4))
                                                   : $urandom;
         if ($urandom_range(0, 1) == 0) begin
            model_predict(upc, etk, etg);
            upd_pred_taken_i = etk; upd_pred_target_i = etg;
         end else begin
            upd_pred_taken_i = $urandom_range(0, 1);
            upd_pred_target_i = ($urandom_range(0, 1) == 0) ? upd_target_i : $urandom;
         end
         #3;
         model_predict(f, etk, etg);
         chk("rnd_ptk",   {31'b0, pred_taken_o}, {31'b0, etk});
         chk("rnd_ptgt",  pred_target_o, etg);
         chk("rnd_mp",    {31'b0, mispredict_o}, {31'b0, model_mp()});
         chk("rnd_redir", redirect_pc_o, upd_taken_i ? upd_target_i : upc + 32'd4);
         chk("rnd_bcnt",  branch_cnt_o, m_bcnt);
         chk("rnd_mcnt",  mispredict_cnt_o, m_mcnt);
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
